// File: rtl/lms_coef_update_if.sv
// ---------------------------------------------------------------------------
// lms_coef_update_if
//   Bundles the sample/error handshakes and the tap/coefficient/status outputs
//   of the LMS coefficient-update engine.
//
//   master : the side that feeds samples and errors (filter wrapper / bench)
//   slave  : the update engine itself
//
//   x_in, sample_valid, sample_ready : sample handshake into the delay line
//   err, err_valid, err_ready        : error handshake that starts an update
//   coef_clr                         : synchronous clear of h0..h3 (aborts)
//   x0..x3                           : tap contents, x0 newest
//   h0..h3                           : coefficients
//   busy, upd_done, sat_flag         : update status
// ---------------------------------------------------------------------------
interface lms_coef_update_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ERR_W  = 10
);
  logic signed [DATA_W-1:0] x_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic signed [ERR_W-1:0]  err;
  logic                     err_valid;
  logic                     err_ready;
  logic                     coef_clr;
  logic signed [DATA_W-1:0] x0;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] x3;
  logic signed [COEF_W-1:0] h0;
  logic signed [COEF_W-1:0] h1;
  logic signed [COEF_W-1:0] h2;
  logic signed [COEF_W-1:0] h3;
  logic                     busy;
  logic                     upd_done;
  logic                     sat_flag;

  modport master (
    output x_in, sample_valid, err, err_valid, coef_clr,
    input  sample_ready, err_ready, x0, x1, x2, x3, h0, h1, h2, h3,
           busy, upd_done, sat_flag
  );

  modport slave (
    input  x_in, sample_valid, err, err_valid, coef_clr,
    output sample_ready, err_ready, x0, x1, x2, x3, h0, h1, h2, h3,
           busy, upd_done, sat_flag
  );
endinterface

// File: rtl/lms_coef_update.sv
// ---------------------------------------------------------------------------
// lms_coef_update
//   LMS weight-update engine and 4-tap delay line for the DA FIR.
//   The delay line shifts in a new sample on each accepted sample handshake.
//   On each accepted error the engine walks the four taps, one per cycle:
//     h_k <= sat(h_k + ((err * x_k) >>> MU_SHIFT))
//   The taps are frozen while the engine is busy, so every tap of one update
//   sees the sample set present when the error was accepted.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active high
//     bus  : lms_coef_update_if.slave (handshakes, taps, coefficients, status)
// ---------------------------------------------------------------------------
module lms_coef_update #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int ERR_W    = 10,
  parameter int MU_SHIFT = 10
) (
  input  logic              clk,
  input  logic              rst,
  lms_coef_update_if.slave  bus
);

  localparam int PROD_W = ERR_W + DATA_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'((2 ** (COEF_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clip a wide sum into the coefficient range.
  function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [SUM_W-1:0] s);
    if (s > C_MAX)      sat_coef = C_MAX[COEF_W-1:0];
    else if (s < C_MIN) sat_coef = C_MIN[COEF_W-1:0];
    else                sat_coef = s[COEF_W-1:0];
  endfunction

  function automatic logic is_clipped(input logic signed [SUM_W-1:0] s);
    is_clipped = (s > C_MAX) || (s < C_MIN);
  endfunction

  state_t                    state;
  logic [1:0]                k;
  logic signed [ERR_W-1:0]   err_r;
  logic                      sat_any;
  logic                      busy_r;
  logic                      upd_done_r;
  logic                      sat_flag_r;
  logic signed [DATA_W-1:0]  tap  [4];
  logic signed [COEF_W-1:0]  coef [4];

  logic                      sample_fire;
  logic signed [DATA_W-1:0]  x_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  delta;
  logic signed [SUM_W-1:0]   sum;
  logic signed [COEF_W-1:0]  h_new;
  logic                      clip;

  // Handshakes: an error offered in IDLE wins over a sample in the same cycle.
  assign bus.err_ready    = (state == IDLE);
  assign bus.sample_ready = (state == IDLE) && !bus.err_valid;
  assign sample_fire      = bus.sample_valid && bus.sample_ready;

  // Tap arithmetic for the tap currently addressed by k. The >>> on a signed
  // product floors toward -inf, so small negative products give -1, not 0.
  always_comb begin
    x_sel = tap[k];
    prod  = PROD_W'(err_r) * PROD_W'(x_sel);
    delta = prod >>> MU_SHIFT;
    sum   = SUM_W'(coef[k]) + SUM_W'(delta);
    h_new = sat_coef(sum);
    clip  = is_clipped(sum);
  end

  // Delay line: only moves on an accepted sample, which implies IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) tap[i] <= '0;
    end else if (sample_fire) begin
      tap[3] <= tap[2];
      tap[2] <= tap[1];
      tap[1] <= tap[0];
      tap[0] <= bus.x_in;
    end
  end

  // Update FSM. coef_clr overrides everything: clears h and drops back to
  // IDLE without a completion pulse, discarding any partial update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      err_r      <= '0;
      sat_any    <= 1'b0;
      busy_r     <= 1'b0;
      upd_done_r <= 1'b0;
      sat_flag_r <= 1'b0;
      for (int i = 0; i < 4; i++) coef[i] <= '0;
    end else begin
      upd_done_r <= 1'b0;
      sat_flag_r <= 1'b0;
      if (bus.coef_clr) begin
        for (int i = 0; i < 4; i++) coef[i] <= '0;
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.err_valid) begin
              err_r   <= bus.err;
              k       <= '0;
              sat_any <= 1'b0;
              busy_r  <= 1'b1;
              state   <= UPD;
            end
          end
          UPD: begin
            coef[k] <= h_new;
            if (clip) sat_any <= 1'b1;
            k <= k + 2'd1;
            if (k == 2'd3) begin
              state      <= DONE;
              upd_done_r <= 1'b1;
              sat_flag_r <= sat_any | clip;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.x0       = tap[0];
  assign bus.x1       = tap[1];
  assign bus.x2       = tap[2];
  assign bus.x3       = tap[3];
  assign bus.h0       = coef[0];
  assign bus.h1       = coef[1];
  assign bus.h2       = coef[2];
  assign bus.h3       = coef[3];
  assign bus.busy     = busy_r;
  assign bus.upd_done = upd_done_r;
  assign bus.sat_flag = sat_flag_r;

endmodule

// File: tb/tb_lms_coef_update.sv
module tb_lms_coef_update;
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int ERR_W    = 10;
  localparam int MU_SHIFT = 10;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference state: plain integers, x[0] newest.
  int mx [4];
  int mh [4];

  typedef struct {
    int s [4];   // samples pushed in order; s[3] ends up as x0
    int e;
    int h [4];   // expected h0..h3 starting from cleared coefficients
    int sat;
  } vec_t;

  vec_t tbl [5];

  lms_coef_update_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ERR_W(ERR_W)) bus ();

  lms_coef_update #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .ERR_W(ERR_W), .MU_SHIFT(MU_SHIFT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // mu * err * x with floor division, written as integer division.
  function automatic int floor_scale(input int p);
    int d;
    d = 1 << MU_SHIFT;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  task automatic model_update(input int e, output int sat);
    int s;
    int lo;
    int hi;
    lo  = -(1 << (COEF_W - 1));
    hi  = (1 << (COEF_W - 1)) - 1;
    sat = 0;
    for (int i = 0; i < 4; i++) begin
      s = mh[i] + floor_scale(e * mx[i]);
      if (s > hi) begin s = hi; sat = 1; end
      if (s < lo) begin s = lo; sat = 1; end
      mh[i] = s;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_taps(input string tag);
    check({tag, "_x0"}, int'(bus.x0), mx[0]);
    check({tag, "_x1"}, int'(bus.x1), mx[1]);
    check({tag, "_x2"}, int'(bus.x2), mx[2]);
    check({tag, "_x3"}, int'(bus.x3), mx[3]);
  endtask

  task automatic check_coefs(input string tag);
    check({tag, "_h0"}, int'(bus.h0), mh[0]);
    check({tag, "_h1"}, int'(bus.h1), mh[1]);
    check({tag, "_h2"}, int'(bus.h2), mh[2]);
    check({tag, "_h3"}, int'(bus.h3), mh[3]);
  endtask

  task automatic push(input int v);
    bus.x_in         = DATA_W'(v);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    mx[3] = mx[2]; mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = v;
  endtask

  task automatic clear_coef();
    bus.coef_clr = 1'b1;
    tick();
    bus.coef_clr = 1'b0;
    for (int i = 0; i < 4; i++) mh[i] = 0;
  endtask

  // Wait for the engine to drop busy; returns busy cycles seen and pulses.
  task automatic wait_idle(output int cycles, output int ndone, output int sf);
    cycles = 0; ndone = 0; sf = 0;
    while (bus.busy && cycles < 20) begin
      if (bus.upd_done) begin ndone++; sf = int'(bus.sat_flag); end
      cycles++;
      tick();
    end
  endtask

  task automatic do_update(input int e, input string tag);
    int cycles;
    int ndone;
    int sf;
    int exp_sat;
    check({tag, "_err_ready"}, int'(bus.err_ready), 1);
    bus.err       = ERR_W'(e);
    bus.err_valid = 1'b1;
    tick();
    bus.err_valid = 1'b0;
    wait_idle(cycles, ndone, sf);
    model_update(e, exp_sat);
    check({tag, "_busy_cycles"}, cycles, 5);
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_sat_flag"}, sf, exp_sat);
    check({tag, "_ready_after"}, int'(bus.err_ready), 1);
    check_coefs(tag);
  endtask

  initial begin
    int cycles;
    int ndone;
    int sf;
    int es;
    int r;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin mx[i] = 0; mh[i] = 0; end

    tbl[0].s = '{-16, 32, 64, 100};  tbl[0].e = 256;  tbl[0].h = '{25, 16, 8, -4};    tbl[0].sat = 0;
    tbl[1].s = '{0, 0, 0, 1};        tbl[1].e = -1;   tbl[1].h = '{-1, 0, 0, 0};      tbl[1].sat = 0;
    tbl[2].s = '{0, 0, 0, 127};      tbl[2].e = 511;  tbl[2].h = '{63, 0, 0, 0};      tbl[2].sat = 0;
    tbl[3].s = '{1, 2, -3, -128};    tbl[3].e = -512; tbl[3].h = '{64, 1, -1, -1};    tbl[3].sat = 0;
    tbl[4].s = '{127, 127, 127, 127}; tbl[4].e = -512; tbl[4].h = '{-64, -64, -64, -64}; tbl[4].sat = 0;

    rst              = 1'b1;
    bus.x_in         = '0;
    bus.sample_valid = 1'b0;
    bus.err          = '0;
    bus.err_valid    = 1'b0;
    bus.coef_clr     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_taps("reset");
    check_coefs("reset");
    check("reset_busy", int'(bus.busy), 0);
    check("reset_upd_done", int'(bus.upd_done), 0);
    check("reset_sample_ready", int'(bus.sample_ready), 1);

    // Table of hand-derived updates, each from cleared coefficients.
    for (int t = 0; t < 5; t++) begin
      clear_coef();
      for (int j = 0; j < 4; j++) push(tbl[t].s[j]);
      check_taps($sformatf("tbl%0d_taps", t));
      do_update(tbl[t].e, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_h0_const", t), int'(bus.h0), tbl[t].h[0]);
      check($sformatf("tbl%0d_h1_const", t), int'(bus.h1), tbl[t].h[1]);
      check($sformatf("tbl%0d_h2_const", t), int'(bus.h2), tbl[t].h[2]);
      check($sformatf("tbl%0d_h3_const", t), int'(bus.h3), tbl[t].h[3]);
    end

    // Floor rounding: -1 gives -1; +1 then rounds to 0 so h0 holds at -1.
    clear_coef();
    push(0); push(0); push(0); push(1);
    do_update(-1, "floor_neg");
    check("floor_neg_h0_const", int'(bus.h0), -1);
    do_update(1, "floor_pos");
    check("floor_pos_h0_const", int'(bus.h0), -1);

    // Positive saturation: build h0=120, then err=511 adds 63.
    clear_coef();
    push(0); push(0); push(0); push(127);
    do_update(511, "satp_a");
    do_update(460, "satp_b");
    check("satp_h0_120", int'(bus.h0), 120);
    do_update(511, "satp_c");
    check("satp_h0_127", int'(bus.h0), 127);

    // Negative saturation: build h0=-120, then err=-512 adds -64.
    clear_coef();
    do_update(-511, "satn_a");
    do_update(-444, "satn_b");
    check("satn_h0_m120", int'(bus.h0), -120);
    do_update(-512, "satn_c");
    check("satn_h0_m128", int'(bus.h0), -128);

    // Samples offered while busy are not consumed.
    push(-16); push(32); push(64); push(100);
    bus.err       = ERR_W'(37);
    bus.err_valid = 1'b1;
    tick();
    bus.err_valid    = 1'b0;
    bus.x_in         = DATA_W'(55);
    bus.sample_valid = 1'b1;
    check("busy_sample_ready", int'(bus.sample_ready), 0);
    tick(); tick(); tick();
    bus.sample_valid = 1'b0;
    wait_idle(cycles, ndone, sf);
    model_update(37, es);
    check_taps("busy_sample");
    check_coefs("busy_sample");

    // Error and sample in the same IDLE cycle: error wins.
    bus.err          = ERR_W'(-200);
    bus.err_valid    = 1'b1;
    bus.x_in         = DATA_W'(77);
    bus.sample_valid = 1'b1;
    #1;
    check("prio_sample_ready", int'(bus.sample_ready), 0);
    tick();
    bus.err_valid    = 1'b0;
    bus.sample_valid = 1'b0;
    check("prio_busy", int'(bus.busy), 1);
    wait_idle(cycles, ndone, sf);
    model_update(-200, es);
    check("prio_done_pulses", ndone, 1);
    check_taps("prio");
    check_coefs("prio");

    // coef_clr while the engine sits at k=2 aborts without a pulse.
    bus.err       = ERR_W'(300);
    bus.err_valid = 1'b1;
    tick();
    bus.err_valid = 1'b0;
    tick();
    tick();
    bus.coef_clr = 1'b1;
    tick();
    bus.coef_clr = 1'b0;
    for (int i = 0; i < 4; i++) mh[i] = 0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_err_ready", int'(bus.err_ready), 1);
    check_coefs("abort");
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.upd_done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        push(int'($urandom_range(0, 255)) - 128);
        check_taps($sformatf("rnd%0d_push", n));
      end else if (r < 9) begin
        do_update(int'($urandom_range(0, 1023)) - 512, $sformatf("rnd%0d_upd", n));
      end else begin
        clear_coef();
        check_coefs($sformatf("rnd%0d_clr", n));
      end
    end

    // Asynchronous reset in the middle of an update.
    bus.err       = ERR_W'(100);
    bus.err_valid = 1'b1;
    tick();
    bus.err_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin mx[i] = 0; mh[i] = 0; end
    check_taps("rst_mid");
    check_coefs("rst_mid");
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_upd_done", int'(bus.upd_done), 0);
    check("rst_mid_sample_ready", int'(bus.sample_ready), 1);
    check("rst_mid_err_ready", int'(bus.err_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    check_coefs("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
